mpc60x_mem_slave: RTL and testbench

Bus arbiter and memory target for the 60x bus driven by the mpc7410 master model. It takes the master's bus requests and grants the address and data buses (BG, DBG). It latches each address tenure (A, TT, TSIZ, TBST) and acknowledges it with AACK. It then completes the data tenure with TA beats against an internal 64-bit-wide memory. The block sits directly downstream of the processor model in the system testbench and is the only bus slave and arbiter on the bus.

---
 rtl/mpc60x_mem_slave_if.sv | 30 +++
 rtl/mpc60x_mem_slave.sv | 161 ++++++++++++++++
 tb/tb_mpc60x_mem_slave.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpc60x_mem_slave_if.sv
// 60x bus bundle between the mpc7410 master model and the memory slave.
// Strobes are active-low; vectors are numbered big-endian (bit 0 = MSB).
interface mpc60x_mem_slave_if;
    logic        br;
    logic        bg;
    logic        dbg;
    logic        ts;
    logic [0:31] a;
    logic [0:4]  tt;
    logic [0:2]  tsiz;
    logic        tbst;
    logic        aack;
    logic        ta;
    logic        tea;
    logic [0:31] dh_i;
    logic [0:31] dl_i;
    logic [0:31] dh_o;
    logic [0:31] dl_o;
    logic        doe;

    modport master (
        output br, ts, a, tt, tsiz, tbst, dh_i, dl_i,
        input  bg, dbg, aack, ta, tea, dh_o, dl_o, doe
    );

    modport slave (
        input  br, ts, a, tt, tsiz, tbst, dh_i, dl_i,
        output bg, dbg, aack, ta, tea, dh_o, dl_o, doe
    );
endinterface

// File: rtl/mpc60x_mem_slave.sv
// 60x bus arbiter plus 64-bit memory target (single outstanding master).
// Optional MPC60X_MEM_TEA_EN: TEA on data tenures outside BASE_HI.
module mpc60x_mem_slave #(
    parameter int         MEM_AW   = 4,
    parameter int         AACK_LAT = 1,
    parameter logic [3:0] BASE_HI  = 4'hA
) (
    input logic               clk,
    input logic               rst,
    mpc60x_mem_slave_if.slave bus
);
    localparam int DEPTH = 1 << MEM_AW;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] ADDR  = 2'd2;
    localparam logic [1:0] DATA  = 2'd3;
    localparam logic [MEM_AW-1:0] LO = MEM_AW'(3);

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [MEM_AW-1:0] idx;
    logic [MEM_AW-1:0] idx_nxt;
    logic [1:0]        left;
    logic              is_data;
    logic              is_rd;
    logic [2:0]        tsiz_q;
    logic              bad;
    logic              bg_q;
    logic              dbg_q;
    logic              aack_q;
    logic              ta_q;
    logic              tea_q;
    logic              doe_q;
    logic [63:0]       dout_q;
    logic [63:0]       mem [DEPTH];

    // TSIZ is captured for visibility only; it does not shape beats.
    wire unused_tsiz = ^tsiz_q;

`ifdef MPC60X_MEM_TEA_EN
    logic [3:0] a_hi;

    // Capture the address region tag at the address tenure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            a_hi <= 4'd0;
        else if (state == GRANT && !bus.ts)
            a_hi <= bus.a[0:3];
    end

    assign bad = is_data && (a_hi != BASE_HI);
`else
    assign bad = 1'b0;
`endif

    // Critical-word-first wrap inside the aligned 4-word line.
    assign idx_nxt = (idx & ~LO) | ((idx + MEM_AW'(1)) & LO);

    // Arbitration, address tenure and data beat sequencing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            idx     <= '0;
            left    <= 2'd0;
            is_data <= 1'b0;
            is_rd   <= 1'b0;
            tsiz_q  <= 3'd0;
            bg_q    <= 1'b1;
            dbg_q   <= 1'b1;
            aack_q  <= 1'b1;
            ta_q    <= 1'b1;
            tea_q   <= 1'b1;
            doe_q   <= 1'b0;
            dout_q  <= 64'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!bus.br) begin
                        bg_q  <= 1'b0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.ts) begin
                        bg_q    <= 1'b1;
                        cnt     <= 3'(AACK_LAT);
                        idx     <= bus.a[29-MEM_AW:28];
                        is_data <= bus.tt[3];
                        is_rd   <= bus.tt[1];
                        left    <= bus.tbst ? 2'd0 : 2'd3;
                        tsiz_q  <= bus.tsiz;
                        state   <= ADDR;
                    end else if (bus.br) begin
                        bg_q  <= 1'b1;
                        state <= IDLE;
                    end
                end
                ADDR: begin
                    if (cnt == 3'd1) begin
                        aack_q <= 1'b0;
                        dbg_q  <= ~is_data;
                        cnt    <= 3'd0;
                    end else if (cnt == 3'd0) begin
                        aack_q <= 1'b1;
                        dbg_q  <= 1'b1;
                        if (!is_data) begin
                            state <= IDLE;
                        end else if (bad) begin
                            tea_q <= 1'b0;
                            state <= DATA;
                        end else begin
                            ta_q  <= 1'b0;
                            doe_q <= is_rd;
                            if (is_rd)
                                dout_q <= mem[idx];
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DATA: begin
                    if (!tea_q) begin
                        tea_q <= 1'b1;
                        state <= IDLE;
                    end else if (left == 2'd0) begin
                        ta_q  <= 1'b1;
                        doe_q <= 1'b0;
                        state <= IDLE;
                    end else begin
                        left <= left - 2'd1;
                        idx  <= idx_nxt;
                        if (is_rd)
                            dout_q <= mem[idx_nxt];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory array: cleared by reset, written on each write TA edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 64'd0;
        end else if (state == DATA && !ta_q && !is_rd) begin
            mem[idx] <= {bus.dh_i, bus.dl_i};
        end
    end

    assign bus.bg   = bg_q;
    assign bus.dbg  = dbg_q;
    assign bus.aack = aack_q;
    assign bus.ta   = ta_q;
    assign bus.tea  = tea_q;
    assign bus.doe  = doe_q;
    assign bus.dh_o = dout_q[63:32];
    assign bus.dl_o = dout_q[31:0];
endmodule

// File: tb/tb_mpc60x_mem_slave.sv
// Scoreboard bench: two slaves (AACK_LAT 1 and 3) share one master.
// Expectations come from a word-array memory model and cycle arithmetic.
module tb_mpc60x_mem_slave;
    typedef struct {
        int cyc;
        bit dbg;
    } ack_t;

    typedef struct {
        int          cyc;
        bit          tea;
        bit          rd;
        logic [63:0] d;
    } beat_t;

`ifdef MPC60X_MEM_TEA_EN
    localparam bit TEA_EN = 1'b1;
`else
    localparam bit TEA_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br = 1'b1;
    logic        ts = 1'b1;
    logic [31:0] a = 32'd0;
    logic [4:0]  tt = 5'd0;
    logic [2:0]  tsiz = 3'd0;
    logic        tbst = 1'b1;
    logic [63:0] wbuf [4];
    int          t0 [2];
    int          cyc = 0;

    logic        bg_w [2];
    logic        dbg_w [2];
    logic        aack_w [2];
    logic        ta_w [2];
    logic        tea_w [2];
    logic        doe_w [2];
    logic [63:0] rd_w [2];

    ack_t        aq [2][$];
    beat_t       bq [2][$];
    logic [63:0] mdl [16];

    int n_chk = 0;
    int n_fail = 0;
    int req_seq = 0;
    int seen_seq = 0;
    int req_kind = 0;
    logic req_exp = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mpc60x_mem_slave_if bif ();
        logic [63:0] wd;

        assign wd = wbuf[2'(cyc - t0[g])];
        assign bif.br = br;
        assign bif.ts = ts;
        assign bif.a = a;
        assign bif.tt = tt;
        assign bif.tsiz = tsiz;
        assign bif.tbst = tbst;
        assign bif.dh_i = wd[63:32];
        assign bif.dl_i = wd[31:0];
        assign bg_w[g] = bif.bg;
        assign dbg_w[g] = bif.dbg;
        assign aack_w[g] = bif.aack;
        assign ta_w[g] = bif.ta;
        assign tea_w[g] = bif.tea;
        assign doe_w[g] = bif.doe;
        assign rd_w[g] = {bif.dh_o, bif.dl_o};

        mpc60x_mem_slave #(
            .MEM_AW  (4),
            .AACK_LAT(g == 0 ? 1 : 3),
            .BASE_HI (4'hA)
        ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bif)
        );
    end

    // Monitor: compares every DUT response against the queued expectation.
    always @(negedge clk) begin
        ack_t  ea;
        beat_t eb;
        bit    ok;
        if (req_seq != seen_seq) begin
            seen_seq = req_seq;
            if (req_kind == 0) begin
                for (int k = 0; k < 2; k++) begin
                    n_chk++;
                    if (bg_w[k] !== req_exp) begin
                        n_fail++;
                        $display("FAIL bg_dut%0d: got %b want %b",
                                 k, bg_w[k], req_exp);
                    end
                end
            end else if (req_kind == 1) begin
                n_chk++;
                n_fail++;
                $display("FAIL grant_timeout: got no BG want BG low");
            end else begin
                for (int k = 0; k < 2; k++) begin
                    n_chk++;
                    if (aq[k].size() != 0 || bq[k].size() != 0) begin
                        n_fail++;
                        $display("FAIL drain_dut%0d: got %0d/%0d left want 0/0",
                                 k, aq[k].size(), bq[k].size());
                    end
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                aq[k].delete();
                bq[k].delete();
                n_chk++;
                if ({bg_w[k], dbg_w[k], aack_w[k], ta_w[k], tea_w[k],
                     doe_w[k], rd_w[k]} !== {6'b111110, 64'd0}) begin
                    n_fail++;
                    $display("FAIL reset_dut%0d: got bg%b dbg%b aack%b ta%b tea%b doe%b d=%h want 11111 0 0",
                             k, bg_w[k], dbg_w[k], aack_w[k], ta_w[k],
                             tea_w[k], doe_w[k], rd_w[k]);
                end
            end else begin
                while (aq[k].size() > 0 && aq[k][0].cyc < cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL aack_missed_dut%0d: got none want cyc %0d",
                             k, aq[k][0].cyc);
                    void'(aq[k].pop_front());
                end
                while (bq[k].size() > 0 && bq[k][0].cyc < cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL beat_missed_dut%0d: got none want cyc %0d",
                             k, bq[k][0].cyc);
                    void'(bq[k].pop_front());
                end
                if (!aack_w[k]) begin
                    n_chk++;
                    if (aq[k].size() == 0) begin
                        n_fail++;
                        $display("FAIL aack_dut%0d: got AACK at cyc %0d want none",
                                 k, cyc);
                    end else begin
                        ea = aq[k].pop_front();
                        if (ea.cyc != cyc || dbg_w[k] !== ea.dbg) begin
                            n_fail++;
                            $display("FAIL aack_dut%0d: got cyc %0d dbg %b want cyc %0d dbg %b",
                                     k, cyc, dbg_w[k], ea.cyc, ea.dbg);
                        end
                    end
                end else if (!dbg_w[k]) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL dbg_dut%0d: got DBG low at cyc %0d want high",
                             k, cyc);
                end
                if (!ta_w[k] || !tea_w[k]) begin
                    n_chk++;
                    if (bq[k].size() == 0) begin
                        n_fail++;
                        $display("FAIL beat_dut%0d: got ta%b tea%b at cyc %0d want none",
                                 k, ta_w[k], tea_w[k], cyc);
                    end else begin
                        eb = bq[k].pop_front();
                        ok = (eb.cyc == cyc);
                        ok = ok && (ta_w[k] === eb.tea);
                        ok = ok && (tea_w[k] === !eb.tea);
                        ok = ok && (doe_w[k] === (eb.rd && !eb.tea));
                        if (eb.rd && !eb.tea)
                            ok = ok && (rd_w[k] === eb.d);
                        if (!ok) begin
                            n_fail++;
                            $display("FAIL beat_dut%0d: got cyc %0d ta%b tea%b doe%b d=%h want cyc %0d tea%b rd%b d=%h",
                                     k, cyc, ta_w[k], tea_w[k], doe_w[k],
                                     rd_w[k], eb.cyc, eb.tea, eb.rd, eb.d);
                        end
                    end
                end else if (doe_w[k]) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL doe_dut%0d: got DOE without TA at cyc %0d want 0",
                             k, cyc);
                end
            end
        end
    end

    task automatic req(input int kind, input logic exp);
        req_kind = kind;
        req_exp = exp;
        req_seq++;
        @(negedge clk);
    endtask

    // One full tenure; abort >= 0 fires reset in that beat of DUT 0.
    task automatic txn(input logic [31:0] addr, input logic [4:0] ttv,
                       input bit single, input int abort);
        int    m;
        int    idx;
        int    w;
        int    nb;
        bit    isd;
        bit    isr;
        bit    bad;
        ack_t  ea;
        beat_t eb;
        @(negedge clk);
        br = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8 && (bg_w[0] || bg_w[1]); i++) begin
            @(posedge clk);
            #1;
        end
        if (bg_w[0] || bg_w[1]) begin
            br = 1'b1;
            req(1, 1'b0);
            return;
        end
        ts = 1'b0;
        br = 1'b1;
        a = addr;
        tt = ttv;
        tbst = single;
        tsiz = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        m = cyc;
        ts = 1'b1;
        idx = int'((addr >> 3) & 32'hF);
        isd = ttv[1];
        isr = ttv[3];
        bad = TEA_EN && isd && (addr[31:28] != 4'hA);
        nb = single ? 1 : 4;
        for (int k = 0; k < 2; k++) begin
            ea.cyc = m + lat(k);
            ea.dbg = !isd;
            aq[k].push_back(ea);
            t0[k] = m + lat(k) + 1;
            if (isd && bad) begin
                eb.cyc = t0[k];
                eb.tea = 1'b1;
                eb.rd = isr;
                eb.d = 64'd0;
                bq[k].push_back(eb);
            end else if (isd) begin
                for (int i = 0; i < nb; i++) begin
                    w = (idx & ~3) | ((idx + i) & 3);
                    eb.cyc = t0[k] + i;
                    eb.tea = 1'b0;
                    eb.rd = isr;
                    eb.d = mdl[w];
                    bq[k].push_back(eb);
                end
            end
        end
        if (isd && !bad && !isr && abort < 0) begin
            for (int i = 0; i < nb; i++)
                mdl[(idx & ~3) | ((idx + i) & 3)] = wbuf[i];
        end
        if (abort >= 0) begin
            repeat (abort + 2) @(posedge clk);
            #2;
            rst = 1'b1;
            for (int i = 0; i < 16; i++)
                mdl[i] = 64'd0;
            @(negedge clk);
            @(negedge clk);
            @(posedge clk);
            #1;
            rst = 1'b0;
        end else begin
            repeat (10) @(posedge clk);
        end
    endtask

    task automatic wr1(input logic [31:0] addr, input logic [63:0] d);
        wbuf[0] = d;
        txn(addr, 5'b00010, 1'b1, -1);
    endtask

    initial begin
        logic [31:0] ra;
        logic [4:0]  rt;
        int          sel;
        for (int i = 0; i < 16; i++)
            mdl[i] = 64'd0;
        for (int i = 0; i < 4; i++)
            wbuf[i] = 64'd0;
        t0[0] = 0;
        t0[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        br = 1'b0;
        @(posedge clk);
        #1;
        req(0, 1'b0);
        br = 1'b1;
        @(posedge clk);
        #1;
        req(0, 1'b1);
        wr1(32'hAAAAAAA8, {32'hAA000000, 32'h12345678});
        txn(32'hAAAAAAA8, 5'b01010, 1'b1, -1);
        for (int i = 4; i < 8; i++)
            wr1(32'hA0000000 + 32'(i * 8), 64'(i));
        txn(32'hA0000030, 5'b01010, 1'b0, -1);
        txn(32'hA0000040, 5'b10000, 1'b1, -1);
        wr1(32'h10000008, 64'hDEAD_BEEF_0000_0001);
        txn(32'hA0000008, 5'b01110, 1'b1, -1);
        for (int i = 0; i < 4; i++)
            wbuf[i] = {32'hB0B0_0000 + 32'(i), $urandom};
        txn(32'hA0000010, 5'b00110, 1'b0, -1);
        txn(32'hA0000018, 5'b01010, 1'b0, -1);
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 4);
            rt = (sel == 0) ? 5'b00010 :
                 (sel == 1) ? 5'b00110 :
                 (sel == 2) ? 5'b01010 :
                 (sel == 3) ? 5'b01110 : 5'b10000;
            ra = {4'hA, 28'($urandom)};
            if ($urandom_range(0, 5) == 0)
                ra[31:28] = 4'($urandom);
            for (int i = 0; i < 4; i++)
                wbuf[i] = {$urandom, $urandom};
            txn(ra, rt, 1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        for (int i = 0; i < 4; i++)
            wbuf[i] = {32'hC0C0_0000 + 32'(i), 32'h1};
        txn(32'hA0000000, 5'b00010, 1'b0, 1);
        txn(32'hAAAAAAA8, 5'b01010, 1'b1, -1);
        txn(32'hA0000000, 5'b01010, 1'b0, -1);
        wr1(32'hA0000078, 64'h0123_4567_89AB_CDEF);
        txn(32'hA0000078, 5'b01010, 1'b1, -1);
        req(2, 1'b0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
